// File: rtl/l0_latency_buffer.sv
// l0_latency_buffer: circular L0 latency memory feeding a first-word-fall-through event FIFO
module l0_latency_buffer #(
  parameter int WIDTH  = 256,
  parameter int DEPTH  = 256,
  parameter int AW     = 8,
  parameter int FDEPTH = 8,
  parameter int FAW    = 3
) (
  input  logic             BCclk,
  input  logic             hrdrstb,
  input  logic [WIDTH-1:0] pipeLine,
  input  logic [7:0]       BCID,
  input  logic [AW-1:0]    latency,
  input  logic             l0,
  input  logic             evt_ready,
  input  logic             clr_overflow,
  output logic             evt_valid,
  output logic [WIDTH-1:0] evt_data,
  output logic [7:0]       evt_bcid,
  output logic [7:0]       evt_l0id,
  output logic [FAW:0]     fifo_count,
  output logic             overflow,
  output logic             pipe_ready
);
  logic [WIDTH+7:0]  mem  [DEPTH];
  logic [WIDTH+15:0] fifo [FDEPTH];
  logic [AW-1:0]     wr_ptr, fill_cnt, leff, rd_addr;
  logic [7:0]        l0id;
  logic [FAW-1:0]    fwp, frp;
  logic [FAW:0]      cnt;
  logic              pop, accept, push, drop;

  assign leff       = (latency == '0) ? AW'(1) : latency;
  assign rd_addr    = wr_ptr - leff;
  assign pipe_ready = fill_cnt >= leff;
  assign evt_valid  = cnt != '0;
  assign fifo_count = cnt;
  assign pop        = evt_valid & evt_ready;
  assign accept     = l0 & pipe_ready;
  // a pop in the same cycle frees the slot of a full FIFO
  assign push       = accept & ((cnt != (FAW+1)'(FDEPTH)) | pop);
  assign drop       = accept & ~push;
  assign {evt_bcid, evt_l0id, evt_data} = evt_valid ? fifo[frp] : '0;

  always_ff @(posedge BCclk)
    mem[wr_ptr] <= {BCID, pipeLine};

  always_ff @(posedge BCclk)
    if (push) fifo[fwp] <= {mem[rd_addr][WIDTH+7:WIDTH], l0id, mem[rd_addr][WIDTH-1:0]};

  always_ff @(posedge BCclk or negedge hrdrstb) begin
    if (!hrdrstb) begin
      wr_ptr   <= '0;
      fill_cnt <= '0;
      l0id     <= '0;
      fwp      <= '0;
      frp      <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr + 1'b1;
      fill_cnt <= fill_cnt + AW'(fill_cnt != AW'(DEPTH-1));
      l0id     <= l0id + 8'(accept);
      fwp      <= fwp + FAW'(push);
      frp      <= frp + FAW'(pop);
      cnt      <= cnt + (FAW+1)'(push) - (FAW+1)'(pop);
      overflow <= drop | (overflow & ~clr_overflow);
    end
  end
endmodule

// File: tb/tb_l0_latency_buffer.sv
// tb_l0_latency_buffer: directed table and sequence checks of the L0 latency buffer
module tb_l0_latency_buffer;
  localparam int W = 256;
  logic         BCclk = 1'b0;
  logic         hrdrstb;
  logic [W-1:0] pipeLine;
  logic [7:0]   BCID, latency;
  logic         l0, evt_ready, clr_overflow;
  logic         evt_valid, overflow, pipe_ready;
  logic [W-1:0] evt_data;
  logic [7:0]   evt_bcid, evt_l0id;
  logic [3:0]   fifo_count;
  int errors = 0, checks = 0, cyc = 0;

  typedef struct {
    logic l0, rdy, clr;
    logic v;
    int   data, id, cnt;
    logic ovf, pr;
  } vec_t;
  vec_t tbl [10];

  l0_latency_buffer dut (
    .BCclk(BCclk), .hrdrstb(hrdrstb), .pipeLine(pipeLine), .BCID(BCID),
    .latency(latency), .l0(l0), .evt_ready(evt_ready), .clr_overflow(clr_overflow),
    .evt_valid(evt_valid), .evt_data(evt_data), .evt_bcid(evt_bcid), .evt_l0id(evt_l0id),
    .fifo_count(fifo_count), .overflow(overflow), .pipe_ready(pipe_ready)
  );

  always #5 BCclk = ~BCclk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic a_l0, input logic a_rdy, input logic a_clr);
    l0 = a_l0; evt_ready = a_rdy; clr_overflow = a_clr;
    pipeLine = W'(cyc); BCID = 8'(cyc);
    @(posedge BCclk); #1;
    cyc++;
  endtask

  task automatic do_reset(input logic [7:0] lat);
    latency = lat; l0 = 0; evt_ready = 0; clr_overflow = 0;
    hrdrstb = 0; #1;
    hrdrstb = 1; cyc = 0;
  endtask

  task automatic chk_head(input string name, input int data, input int id);
    chk({name, "_valid"}, W'(evt_valid), W'(1));
    chk({name, "_data"}, evt_data, W'(data));
    chk({name, "_bcid"}, W'(evt_bcid), W'(8'(data)));
    chk({name, "_l0id"}, W'(evt_l0id), W'(8'(id)));
  endtask

  initial begin
    tbl[0] = '{0,0,0, 0,0,0,0, 0,0};
    tbl[1] = '{1,0,0, 0,0,0,0, 0,0};
    tbl[2] = '{1,0,0, 0,0,0,0, 0,1};
    tbl[3] = '{0,0,0, 0,0,0,0, 0,1};
    tbl[4] = '{0,0,0, 0,0,0,0, 0,1};
    tbl[5] = '{1,0,0, 1,2,0,1, 0,1};
    tbl[6] = '{0,1,0, 0,0,0,0, 0,1};
    tbl[7] = '{1,0,0, 1,4,1,1, 0,1};
    tbl[8] = '{1,1,0, 1,5,2,1, 0,1};
    tbl[9] = '{0,1,1, 0,0,0,0, 0,1};

    // latency 3 from reset: early triggers ignored, then push/pop/simultaneous
    do_reset(3);
    chk("rst_valid", W'(evt_valid), W'(0));
    chk("rst_count", W'(fifo_count), W'(0));
    chk("rst_ovf", W'(overflow), W'(0));
    chk("rst_pr", W'(pipe_ready), W'(0));
    chk("rst_data", evt_data, W'(0));
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].l0, tbl[i].rdy, tbl[i].clr);
      chk($sformatf("tbl%0d_valid", i), W'(evt_valid), W'(tbl[i].v));
      chk($sformatf("tbl%0d_count", i), W'(fifo_count), W'(tbl[i].cnt));
      chk($sformatf("tbl%0d_ovf", i), W'(overflow), W'(tbl[i].ovf));
      chk($sformatf("tbl%0d_pr", i), W'(pipe_ready), W'(tbl[i].pr));
      if (tbl[i].v) chk_head($sformatf("tbl%0d", i), tbl[i].data, tbl[i].id);
    end

    // latency 10, trigger at cycle 50
    do_reset(10);
    repeat (50) step(0, 0, 0);
    chk("lat10_pre_valid", W'(evt_valid), W'(0));
    step(1, 0, 0);
    chk_head("lat10", 40, 0);

    // overflow: 9 triggers into 8 slots, drain, l0id gap, clear
    do_reset(4);
    repeat (4) step(0, 0, 0);
    for (int k = 0; k < 9; k++) begin
      step(1, 0, 0);
      if (k == 7) begin
        chk("full8_count", W'(fifo_count), W'(8));
        chk("full8_ovf", W'(overflow), W'(0));
      end
    end
    chk("ovf_count", W'(fifo_count), W'(8));
    chk("ovf_set", W'(overflow), W'(1));
    for (int k = 0; k < 8; k++) begin
      chk_head($sformatf("drain%0d", k), k, k);
      step(0, 1, 0);
    end
    chk("drained_valid", W'(evt_valid), W'(0));
    chk("drained_count", W'(fifo_count), W'(0));
    step(1, 0, 0);
    chk_head("gap", 17, 9);
    chk("ovf_sticky", W'(overflow), W'(1));
    step(0, 0, 1);
    chk("ovf_clr", W'(overflow), W'(0));

    // full FIFO with simultaneous pop and trigger: no drop
    repeat (7) step(1, 0, 0);
    chk("refill_count", W'(fifo_count), W'(8));
    step(1, 1, 0);
    chk("pushpop_count", W'(fifo_count), W'(8));
    chk("pushpop_ovf", W'(overflow), W'(0));
    chk("pushpop_head", W'(evt_l0id), W'(10));
    // drop in the same cycle as clear leaves overflow set
    step(1, 0, 1);
    chk("dropclr_ovf", W'(overflow), W'(1));
    chk("dropclr_count", W'(fifo_count), W'(8));

    // reset mid-operation with 5 queued events
    do_reset(4);
    repeat (4) step(0, 0, 0);
    repeat (5) step(1, 0, 0);
    chk("pre_rst_count", W'(fifo_count), W'(5));
    hrdrstb = 0; #1;
    chk("mid_rst_valid", W'(evt_valid), W'(0));
    chk("mid_rst_count", W'(fifo_count), W'(0));
    chk("mid_rst_data", evt_data, W'(0));
    chk("mid_rst_bcid", W'(evt_bcid), W'(0));
    chk("mid_rst_l0id", W'(evt_l0id), W'(0));
    chk("mid_rst_pr", W'(pipe_ready), W'(0));
    #1 hrdrstb = 1; cyc = 0;
    repeat (4) step(0, 0, 0);
    chk("post_rst_pr", W'(pipe_ready), W'(1));
    step(1, 0, 0);
    chk_head("post_rst", 0, 0);

    // latency 255 across memory wrap, then latency 0 acts as 1
    do_reset(255);
    repeat (254) step(0, 0, 0);
    chk("lat255_pr_lo", W'(pipe_ready), W'(0));
    step(0, 0, 0);
    chk("lat255_pr_hi", W'(pipe_ready), W'(1));
    repeat (345) step(0, 0, 0);
    step(1, 0, 0);
    chk_head("lat255", 345, 0);
    step(0, 1, 0);
    latency = 0;
    step(1, 0, 0);
    chk_head("lat0", 601, 1);
    chk("lat0_pr", W'(pipe_ready), W'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
